btb_next_pc: RTL and testbench

- Next-PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating predictors.
- Sits directly upstream of the PC register.
  - Takes the current fetch PC (PC register output).
  - Produces the value loaded into the PC register on the next edge.
- Trained and corrected by resolved control-flow information from EX.
- Raises the flush for the IF/ID and ID/EX stages on a mispredict.

---
 rtl/btb_next_pc_pkg.sv | 30 +++
 rtl/btb_next_pc_mem.sv | 50 +++++
 rtl/btb_next_pc.sv | 91 +++++++++
 tb/tb_btb_next_pc.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/btb_next_pc_pkg.sv
// Shared types and helpers for the BTB-based next-PC generator.
package btb_next_pc_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned TGT_W     = 30;
    // Widest tag any legal BTB size needs (BTB_ENTRIES=2); narrower tags are zero-extended.
    localparam int unsigned TAG_MAX_W = 29;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [TGT_W-1:0]     target;
        ctr_t                 ctr;
    } btb_entry_t;

    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr_t'(ctr + 2'd1);
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr_t'(ctr - 2'd1);
    endfunction

endpackage

// File: rtl/btb_next_pc_mem.sv
// Direct-mapped BTB entry array: lookup and update-probe read ports, one synchronous write port.
module btb_mem
    import btb_next_pc_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [IDX_W-1:0] i_ridx,
    output btb_entry_t       o_rdata,
    input  logic [IDX_W-1:0] i_pidx,
    output btb_entry_t       o_pdata,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  btb_entry_t       i_wdata
);

    localparam int unsigned N = 1 << IDX_W;

    logic [N-1:0]         r_valid;
    ctr_t                 r_ctr [N];
    logic [TAG_MAX_W-1:0] r_tag [N];
    logic [TGT_W-1:0]     r_tgt [N];

    // Only valid and ctr are reset; tag/target are don't-care while invalid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < int'(N); i++) begin
                r_ctr[i] <= CTR_WNT;
            end
        end else if (i_we) begin
            r_valid[i_widx] <= i_wdata.valid;
            r_ctr[i_widx]   <= i_wdata.ctr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_tag[i_widx] <= i_wdata.tag;
            r_tgt[i_widx] <= i_wdata.target;
        end
    end

    assign o_rdata = '{valid: r_valid[i_ridx], tag: r_tag[i_ridx],
                       target: r_tgt[i_ridx], ctr: r_ctr[i_ridx]};
    assign o_pdata = '{valid: r_valid[i_pidx], tag: r_tag[i_pidx],
                       target: r_tgt[i_pidx], ctr: r_ctr[i_pidx]};

endmodule

// File: rtl/btb_next_pc.sv
// Next-PC generator: BTB lookup, mispredict redirect/flush, and BTB training from EX.
module btb_next_pc
    import btb_next_pc_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_stall_req,
    input  logic            i_ex_valid,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic            i_ex_taken,
    input  logic [XLEN-1:0] i_ex_target,
    input  logic            i_ex_pred_taken,
    input  logic [XLEN-1:0] i_ex_pred_target,
    output logic [XLEN-1:0] o_pc_next,
    output logic            o_pc_stall,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    output logic            o_flush
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [IDX_W-1:0]     w_idx;
    logic [IDX_W-1:0]     w_ex_idx;
    logic [TAG_MAX_W-1:0] w_tag;
    logic [TAG_MAX_W-1:0] w_ex_tag;
    btb_entry_t           w_rd;
    btb_entry_t           w_pd;
    btb_entry_t           w_wdata;
    logic                 w_hit;
    logic                 w_ex_hit;
    logic                 w_pred_taken;
    logic [XLEN-1:0]      w_pred_target;
    logic                 w_mispred;
    logic [XLEN-1:0]      w_redirect;
    logic                 w_we;

    assign w_idx    = i_pc[IDX_W+1:2];
    assign w_ex_idx = i_ex_pc[IDX_W+1:2];
    assign w_tag    = TAG_MAX_W'(i_pc[31:IDX_W+2]);
    assign w_ex_tag = TAG_MAX_W'(i_ex_pc[31:IDX_W+2]);

    btb_mem #(.IDX_W(IDX_W)) u_mem (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ridx  (w_idx),
        .o_rdata (w_rd),
        .i_pidx  (w_ex_idx),
        .o_pdata (w_pd),
        .i_we    (w_we),
        .i_widx  (w_ex_idx),
        .i_wdata (w_wdata)
    );

    // Lookup, mispredict detection and next-PC priority (redirect beats stall).
    always_comb begin
        w_hit         = w_rd.valid && (w_rd.tag == w_tag);
        w_pred_taken  = w_hit && w_rd.ctr[1];
        w_pred_target = w_pred_taken ? {w_rd.target, 2'b00} : i_pc + 32'd4;
        w_mispred     = i_ex_valid && ((i_ex_taken != i_ex_pred_taken) ||
                        (i_ex_taken && (i_ex_target != i_ex_pred_target)));
        w_redirect    = i_ex_taken ? i_ex_target : i_ex_pc + 32'd4;

        o_pred_taken  = w_pred_taken;
        o_pred_target = w_pred_target;
        o_flush       = w_mispred;
        o_pc_next     = w_mispred ? w_redirect : w_pred_target;
        o_pc_stall    = i_stall_req && !w_mispred;
    end

    // Training: hits update counter (and target when taken); taken misses allocate weakly taken.
    always_comb begin
        w_ex_hit       = w_pd.valid && (w_pd.tag == w_ex_tag);
        w_we           = i_ex_valid && (w_ex_hit || i_ex_taken);
        w_wdata        = w_pd;
        w_wdata.valid  = 1'b1;
        w_wdata.tag    = w_ex_tag;
        if (i_ex_taken) begin
            w_wdata.target = i_ex_target[31:2];
        end
        w_wdata.ctr    = w_ex_hit ? sat_update(w_pd.ctr, i_ex_taken) : CTR_WT;
    end

    logic unused_tag_w;
    assign unused_tag_w = (TAG_W == 0);

endmodule

// File: tb/tb_btb_next_pc.sv
// Bench for btb_next_pc: directed vectors, per-cycle compare against a word-address BTB model.
module tb_btb_next_pc;

    localparam int N = 16;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_pc;
    logic        i_stall_req;
    logic        i_ex_valid;
    logic [31:0] i_ex_pc;
    logic        i_ex_taken;
    logic [31:0] i_ex_target;
    logic        i_ex_pred_taken;
    logic [31:0] i_ex_pred_target;
    logic [31:0] o_pc_next;
    logic        o_pc_stall;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        o_flush;

    btb_next_pc #(.BTB_ENTRIES(N)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_pc             (i_pc),
        .i_stall_req      (i_stall_req),
        .i_ex_valid       (i_ex_valid),
        .i_ex_pc          (i_ex_pc),
        .i_ex_taken       (i_ex_taken),
        .i_ex_target      (i_ex_target),
        .i_ex_pred_taken  (i_ex_pred_taken),
        .i_ex_pred_target (i_ex_pred_target),
        .o_pc_next        (o_pc_next),
        .o_pc_stall       (o_pc_stall),
        .o_pred_taken     (o_pred_taken),
        .o_pred_target    (o_pred_target),
        .o_flush          (o_flush)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: each slot remembers the full word address of the branch it belongs to.
    bit          m_valid [N];
    logic [29:0] m_word  [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
    endtask

    always @(negedge i_rst_n) model_clear();

    always @(posedge i_clk) begin
        if (i_rst_n && i_ex_valid) begin
            int  k;
            bit  h;
            k = int'((i_ex_pc >> 2) % N);
            h = m_valid[k] && (m_word[k] == i_ex_pc[31:2]);
            if (h) begin
                if (i_ex_taken) begin
                    m_ctr[k] = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
                    m_tgt[k] = i_ex_target & 32'hFFFF_FFFC;
                end else begin
                    m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
                end
            end else if (i_ex_taken) begin
                m_valid[k] = 1'b1;
                m_word[k]  = i_ex_pc[31:2];
                m_tgt[k]   = i_ex_target & 32'hFFFF_FFFC;
                m_ctr[k]   = 2;
            end
        end
    end

    // Every cycle: outputs must match the model's view of the current inputs.
    always @(negedge i_clk) begin
        if (chk_en) begin
            int          k;
            bit          pt, mis;
            logic [31:0] ptg, nxt;
            k   = int'((i_pc >> 2) % N);
            pt  = m_valid[k] && (m_word[k] == i_pc[31:2]) && (m_ctr[k] >= 2);
            ptg = pt ? m_tgt[k] : i_pc + 32'd4;
            mis = i_ex_valid && ((i_ex_taken != i_ex_pred_taken) ||
                  (i_ex_taken && (i_ex_target != i_ex_pred_target)));
            nxt = mis ? (i_ex_taken ? i_ex_target : i_ex_pc + 32'd4) : ptg;
            chk("cmp_pc_next", o_pc_next, nxt);
            chk("cmp_pred_taken", 32'(o_pred_taken), 32'(pt));
            chk("cmp_pred_target", o_pred_target, ptg);
            chk("cmp_flush", 32'(o_flush), 32'(mis));
            chk("cmp_pc_stall", 32'(o_pc_stall), 32'(i_stall_req && !mis));
        end
    end

    task automatic drive(input logic [31:0] pc, input logic stall, input logic exv,
                         input logic [31:0] expc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
        @(posedge i_clk);
        #1;
        i_pc             = pc;
        i_stall_req      = stall;
        i_ex_valid       = exv;
        i_ex_pc          = expc;
        i_ex_taken       = tk;
        i_ex_target      = tgt;
        i_ex_pred_taken  = ptk;
        i_ex_pred_target = ptgt;
    endtask

    task automatic lookup(input logic [31:0] pc);
        drive(pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic lit(input string nm, input logic [31:0] nxt, input logic pt,
                       input logic fl, input logic st);
        #1;
        chk({nm, "_next"},  o_pc_next, nxt);
        chk({nm, "_ptk"},   32'(o_pred_taken), 32'(pt));
        chk({nm, "_flush"}, 32'(o_flush), 32'(fl));
        chk({nm, "_stall"}, 32'(o_pc_stall), 32'(st));
    endtask

    initial begin
        model_clear();
        i_rst_n = 1'b0;
        i_pc = 32'h100; i_stall_req = 1'b0; i_ex_valid = 1'b0; i_ex_pc = '0;
        i_ex_taken = 1'b0; i_ex_target = '0; i_ex_pred_taken = 1'b0; i_ex_pred_target = '0;
        chk_en = 1'b1;
        #1;
        lit("reset", 32'h104, 1'b0, 1'b0, 1'b0);
        chk("reset_ptgt", o_pred_target, 32'h104);
        @(negedge i_clk);
        #1 i_rst_n = 1'b1;

        lookup(32'h100);                     lit("t1_idle", 32'h104, 0, 0, 0);
        drive(32'h100, 0, 1, 32'h100, 1, 32'h200, 0, 32'h104);
        lit("t2_cold", 32'h200, 0, 1, 0);
        lookup(32'h100);                     lit("t2_hit", 32'h200, 1, 0, 0);

        drive(32'h100, 0, 1, 32'h100, 1, 32'h200, 1, 32'h200);
        lit("t3_tk1", 32'h200, 1, 0, 0);
        drive(32'h100, 0, 1, 32'h100, 1, 32'h200, 1, 32'h200);
        drive(32'h100, 0, 1, 32'h100, 0, 32'h0, 1, 32'h200);
        lit("t3_nt1", 32'h104, 1, 1, 0);
        lookup(32'h100);                     lit("t3_still", 32'h200, 1, 0, 0);
        drive(32'h100, 0, 1, 32'h100, 0, 32'h0, 1, 32'h200);
        lit("t3_nt2", 32'h104, 1, 1, 0);
        lookup(32'h100);                     lit("t3_cold", 32'h104, 0, 0, 0);

        drive(32'h100, 0, 1, 32'h100, 1, 32'h200, 0, 32'h104);
        lookup(32'h100);                     lit("t4_hit", 32'h200, 1, 0, 0);
        drive(32'h100, 0, 1, 32'h100, 1, 32'h300, 1, 32'h200);
        lit("t4_mis", 32'h300, 1, 1, 0);
        lookup(32'h100);                     lit("t4_new", 32'h300, 1, 0, 0);

        drive(32'h100, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        lit("t5_stall", 32'h300, 1, 0, 1);
        drive(32'h100, 1, 1, 32'h100, 0, 32'h0, 1, 32'h300);
        lit("t5_redir", 32'h104, 1, 1, 0);

        // Same-cycle allocate to index 0: lookup still sees the old 0x100 owner.
        drive(32'h140, 0, 1, 32'h140, 1, 32'h500, 0, 32'h144);
        lit("t6_alloc", 32'h500, 0, 1, 0);
        chk("t6_wtr_ptgt", o_pred_target, 32'h144);
        lookup(32'h100);                     lit("t6_evict", 32'h104, 0, 0, 0);
        lookup(32'h140);                     lit("t6_hit", 32'h500, 1, 0, 0);
        lookup(32'hFFFF_FFFC);               lit("t6_wrap", 32'h0, 0, 0, 0);

        lookup(32'h140);
        #1 i_rst_n = 1'b0;
        lit("t6_rst", 32'h144, 0, 0, 0);
        @(negedge i_clk);
        #1 i_rst_n = 1'b1;
        drive(32'h140, 0, 1, 32'h140, 1, 32'h600, 0, 32'h144);
        lit("t6_realloc", 32'h600, 0, 1, 0);
        lookup(32'h140);                     lit("t6_post", 32'h600, 1, 0, 0);
        lookup(32'h100);

        @(posedge i_clk);
        #1 chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
